// File: rtl/pe_inst_scheduler_pkg.sv
// Shared constants for the PE instruction scheduler: default geometry, instruction
// field positions, opcode names and FSM state encodings.
package pe_inst_scheduler_pkg;

  localparam int PE_INST_WIDTH = 64;
  localparam int PE_DEPTH      = 16;
  localparam int PE_AW         = 4;
  localparam int PE_LOOP_W     = 8;
  localparam int PE_WB_LAT     = 5;

  localparam int PE_WB_BIT     = PE_INST_WIDTH - 1;
  localparam int PE_OPC_LSB    = 24;
  localparam int PE_OPC_MSB    = 26;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MUL = 3'd3,
    OP_MAC = 3'd4,
    OP_MOV = 3'd5,
    OP_LD  = 3'd6,
    OP_ST  = 3'd7
  } pe_opcode_e;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/pe_inst_scheduler.sv
// Program buffer plus issue sequencer feeding the PE control decoder; loops the
// program, spaces out write-back instructions and drains write-back before done.
//
// state    | meaning
// ST_IDLE  | waiting for start; program buffer writable; start may issue entry 0 directly
// ST_ISSUE | issuing one instruction per unstalled cycle in pc order
// ST_GAP   | write-back hazard spacing, gap counts down to 1 (stall ignored)
// ST_DRAIN | last instruction issued, waiting out write-back latency
// ST_DONE  | registers the done pulse, returns to idle
module pe_inst_scheduler
  import pe_inst_scheduler_pkg::*;
#(
  parameter int INST_WIDTH = PE_INST_WIDTH,
  parameter int DEPTH      = PE_DEPTH,
  parameter int AW         = PE_AW,
  parameter int LOOP_W     = PE_LOOP_W,
  parameter int WB_LAT     = PE_WB_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_v,
  input  logic [AW-1:0]         ld_addr,
  input  logic [INST_WIDTH-1:0] ld_inst,
  input  logic [AW:0]           prog_len,
  input  logic [LOOP_W-1:0]     loop_cnt,
  input  logic                  start,
  input  logic                  stall,
  output logic                  inst_v,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  busy,
  output logic                  done,
  output logic                  ld_err
);

  localparam int GAP_W = $clog2(WB_LAT + 1);
  localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'(WB_LAT);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [AW:0]       LEN_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [LOOP_W-1:0] LOOP_ONE = LOOP_W'(1);

  logic [INST_WIDTH-1:0] prog_mem [DEPTH];

  logic [2:0]        state;
  logic [AW-1:0]     pc;
  logic [LOOP_W-1:0] loop;
  logic [GAP_W-1:0]  gap;
  logic [AW:0]       len_q;
  logic [LOOP_W-1:0] loops_q;

  logic                  idle;
  logic                  accept;
  logic                  issue_en;
  logic [AW:0]           eff_len;
  logic [LOOP_W-1:0]     eff_loops;
  logic [AW-1:0]         eff_pc;
  logic [LOOP_W-1:0]     eff_loop;
  logic [INST_WIDTH-1:0] issue_inst;
  logic                  last_pc;
  logic                  last_loop;
  logic [AW-1:0]         adv_pc;
  logic [LOOP_W-1:0]     adv_loop;
  logic [2:0]            adv_state;
  logic [GAP_W-1:0]      adv_gap;

  assign idle   = (state == ST_IDLE);
  assign accept = idle && start;

  // In idle the run parameters come straight from the ports so that entry 0 can
  // issue on the same edge that accepts start.
  always_comb begin
    eff_len   = len_q;
    eff_loops = loops_q;
    eff_pc    = pc;
    eff_loop  = loop;
    if (idle) begin
      eff_len   = prog_len;
      eff_loops = (loop_cnt == '0) ? LOOP_ONE : loop_cnt;
      eff_pc    = '0;
      eff_loop  = '0;
    end
  end

  assign issue_en = !stall && ((accept && (prog_len != '0)) || (state == ST_ISSUE));

  // A load landing on the same edge as start must be seen by the first issue.
  assign issue_inst = (idle && ld_v && (ld_addr == eff_pc)) ? ld_inst : prog_mem[eff_pc];

  assign last_pc   = ({1'b0, eff_pc} == (eff_len - LEN_ONE));
  assign last_loop = (eff_loop == (eff_loops - LOOP_ONE));

  always_comb begin
    adv_pc    = eff_pc + 1'b1;
    adv_loop  = eff_loop;
    adv_state = ST_ISSUE;
    adv_gap   = gap;
    if (last_pc) begin
      adv_pc   = '0;
      adv_loop = eff_loop + LOOP_ONE;
    end
    if (last_pc && last_loop) begin
      adv_state = ST_DRAIN;
      adv_gap   = GAP_INIT;
    end else if (issue_inst[INST_WIDTH-1]) begin
      adv_state = ST_GAP;
      adv_gap   = GAP_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_v && idle) begin
      prog_mem[ld_addr] <= ld_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= '0;
      loop    <= '0;
      gap     <= '0;
      len_q   <= '0;
      loops_q <= '0;
      inst_v  <= 1'b0;
      inst    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ld_err  <= 1'b0;
    end else begin
      done   <= 1'b0;
      ld_err <= ld_v && !idle;
      inst_v <= issue_en;
      if (issue_en) begin
        inst <= issue_inst;
      end

      case (state)
        ST_IDLE: begin
          busy <= accept;
          if (accept) begin
            len_q   <= prog_len;
            loops_q <= eff_loops;
            if (prog_len == '0) begin
              state <= ST_DONE;
            end else if (issue_en) begin
              pc    <= adv_pc;
              loop  <= adv_loop;
              state <= adv_state;
              gap   <= adv_gap;
            end else begin
              pc    <= '0;
              loop  <= '0;
              state <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          if (issue_en) begin
            pc    <= adv_pc;
            loop  <= adv_loop;
            state <= adv_state;
            gap   <= adv_gap;
          end
        end

        ST_GAP: begin
          gap <= gap - GAP_ONE;
          if (gap == GAP_ONE) begin
            state <= ST_ISSUE;
          end
        end

        ST_DRAIN: begin
          gap <= gap - GAP_ONE;
          if (gap == GAP_ONE) begin
            state <= ST_DONE;
          end
        end

        // busy stays up through the done pulse and drops on the following idle edge
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
